// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - ALUOp encodings OP_ADD..OP_NOT (101-111 are illegal)
//   - is_legal_op(): true for encodings the ALU implements
//   - state_t: sequencer FSM states
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// sync_cmd_fifo: single-clock FIFO holding packed ALU commands.
// Ports:
//   clk, rst          clock, async active-high reset (empties the FIFO)
//   push, din         write request and data; ignored while full
//   pop, dout         read request and head data; ignored while empty
//   full, empty       occupancy flags, derived from registered state
module sync_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    // One extra bit so a full FIFO is distinguishable from an empty one.
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two
            // makes them wrap naturally.
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the ALU interface.
// Buffers commands in a FIFO, issues them one at a time to a combinational
// ALU, captures Result/Zero and returns them on a valid/ready stream.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_valid/ready, cmd_a/b/op      command stream in
//   alu_a/b/op                       registered operands to the ALU
//   alu_result, alu_zero             combinational ALU outputs
//   rsp_valid/ready, rsp_result/zero/op/err   response stream out
//   busy                             work buffered or in flight
//   done_count                       responses handed off (wraps)
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [2:0]       rsp_op,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       done_count
);

    localparam int CW = 2*WIDTH + 3;

    state_t           state, state_nxt;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    head;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic             pop, capture, rsp_done;
    logic [2:0]       op_q;    // op of the command in flight, legal or not
    logic             err_q;   // command in flight carries an illegal op

    assign cmd_ready = !fifo_full;
    assign head_op   = head[CW-1 -: 3];
    assign head_a    = head[2*WIDTH-1 -: WIDTH];
    assign head_b    = head[WIDTH-1:0];

    sync_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   ({cmd_op, cmd_a, cmd_b}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    // Back-to-back issue keeps the rate at one response per 2 cycles.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rsp_valid follows the state directly, so it drops as soon as rst rises.
    assign rsp_valid = (state == RESP);
    assign busy      = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
            done_count <= '0;
        end else begin
            if (pop) begin
                op_q  <= head_op;
                err_q <= !is_legal_op(head_op);
                // An illegal op never reaches the ALU; its operand registers
                // keep the last legal command.
                if (is_legal_op(head_op)) begin
                    alu_a  <= head_a;
                    alu_b  <= head_b;
                    alu_op <= head_op;
                end
            end
            if (capture) begin
                rsp_result <= err_q ? '0   : alu_result;
                rsp_zero   <= err_q ? 1'b0 : alu_zero;
                rsp_op     <= op_q;
                rsp_err    <= err_q;
            end
            if (rsp_done) done_count <= done_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [3:0] rsp_result;
    logic       rsp_zero, rsp_err, busy;
    logic [2:0] rsp_op;
    logic [7:0] done_count;

    typedef struct packed {
        logic [3:0] res;
        logic       zero;
        logic [2:0] op;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0, fails = 0, n_sent = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy), .done_count(done_count)
    );

    // The real combinational ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOT:  alu_result = ~alu_a;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input logic [2:0] op);
        exp_t e;
        int   r;
        e.op  = op;
        e.err = 1'b0;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b + 16;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = 15 - a;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        r      = r % 16;
        e.res  = r[3:0];
        e.zero = (r == 0) && !e.err;
        return e;
    endfunction

    // Handshake completes at the next rising edge; check it half a cycle early.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_zero",   rsp_zero,   mon_e.zero);
                chk("rsp_op",     rsp_op,     mon_e.op);
                chk("rsp_err",    rsp_err,    mon_e.err);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        sbq.push_back(model(a, b, op));
        n_sent++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_left", sbq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_count", done_count, 0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // 1: ADD latency -- rsp_valid rises after the second edge past accept
        @(posedge clk); #1;
        send(4'b0101, 4'b0011, OP_ADD);
        chk("lat_e0_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_e1_valid", rsp_valid, 0);
        chk("lat_e1_busy", busy, 1);
        @(posedge clk); #1;
        chk("lat_e2_valid", rsp_valid, 1);
        chk("lat_e2_result", rsp_result, 4'b1000);
        drain();

        // 2, 3: zero results, wrap, logic ops
        send(4'b0101, 4'b0101, OP_SUB);
        send(4'b1111, 4'b0001, OP_ADD);
        send(4'b0101, 4'b1111, OP_NOT);
        send(4'b0101, 4'b0011, OP_AND);
        send(4'b0101, 4'b0011, OP_OR);
        send(4'b0010, 4'b0111, OP_SUB);
        drain();

        // 4: back-pressure fills the FIFO
        rsp_ready = 1'b0;
        send(4'h1, 4'h2, OP_ADD);
        send(4'h7, 4'h3, OP_SUB);
        send(4'hc, 4'ha, OP_AND);
        send(4'h0, 4'h0, OP_NOT);
        send(4'h9, 4'h6, OP_OR);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        chk("hold_result_a", rsp_result, sbq[0].res);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result_b", rsp_result, sbq[0].res);
        chk("hold_op", rsp_op, sbq[0].op);
        chk("still_full", cmd_ready, 0);
        rsp_ready = 1'b1;
        drain();
        chk("done_count_bp", done_count, n_sent);
        chk("idle_busy", busy, 0);

        // 5: illegal op leaves the ALU registers alone
        send(4'h9, 4'h6, 3'b111);
        drain();
        chk("illegal_alu_op", alu_op, OP_OR);
        chk("illegal_alu_a", alu_a, 4'h9);
        send(4'h2, 4'h2, OP_ADD);
        drain();
        chk("legal_after_illegal_op", alu_op, OP_ADD);
        chk("done_count_5", done_count, n_sent);

        // 6: reset while holding a response with 3 queued
        rsp_ready = 1'b0;
        send(4'h3, 4'h1, OP_ADD);
        send(4'h3, 4'h1, OP_SUB);
        send(4'h3, 4'h1, OP_AND);
        send(4'h3, 4'h1, OP_OR);
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done_count", done_count, 0);
        sbq.delete();
        n_sent = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        send(4'h4, 4'h4, OP_SUB);
        drain();
        chk("post_rst_done_count", done_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
